// File: rtl/move_issuer_if.sv
// move_issuer_if: request/response link between the move issuer and the combinational frame tracker.
interface move_issuer_if;
   logic [2:0] move;
   logic [4:0] state;
   logic [4:0][4:0][2:0] frame;
   logic [2:0] color;
   logic complete;
   logic [4:0][4:0][2:0] frame_o;
   modport master (output move, state, frame, color, input complete, frame_o);
   modport slave (input move, state, frame, color, output complete, frame_o);
endinterface

// File: rtl/move_issuer.sv
// move_issuer: turns buttons and gravity into single-cycle tracker requests and holds the working piece.
module move_issuer #(
   parameter int GRAVITY_TICKS = 50,
   parameter int DAS_TICKS = 10,
   parameter int ARR_TICKS = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic tick,
   input  logic btn_left,
   input  logic btn_right,
   input  logic btn_rol,
   input  logic btn_ror,
   input  logic btn_down,
   input  logic load,
   input  logic [4:0] state_d,
   input  logic [4:0][4:0][2:0] frame_d,
   input  logic [2:0] color_d,
   move_issuer_if.master trk,
   output logic busy,
   output logic move_ok,
   output logic move_fail,
   output logic landed
);
   localparam int RMAX = DAS_TICKS > ARR_TICKS ? DAS_TICKS : ARR_TICKS;
   localparam int RW = $clog2(RMAX + 1);
   localparam int GW = $clog2(GRAVITY_TICKS + 1);
   typedef enum logic [1:0] {EMPTY, READY, ISSUE} fsm_t;
   typedef enum logic [2:0] {IDLE, LEFT, RIGHT, ROL, ROR, DOWN} move_t;
   fsm_t fsm, fsm_n;
   move_t mv;
   logic [4:0] btn, prev, rise;
   logic [5:0] pend, pend_n, src, src_n, set, hit, pick;
   logic [1:0][RW-1:0] rep, rep_n;
   logic [1:0] fire;
   logic [GW-1:0] grav, grav_n;
   logic wrap, both, ok_n, fail_n, land_n;
   logic [4:0][4:0][2:0] frame;
   logic [4:0] state;
   logic [2:0] color;
   // button order {down, ror, rol, right, left}; request order {grav, ror, rol, right, left, down}
   assign btn = {btn_down, btn_ror, btn_rol, btn_right, btn_left};
   assign rise = btn & ~prev;
   assign both = btn[0] & btn[1];
   assign wrap = tick && grav == GW'(GRAVITY_TICKS - 1);
   assign grav_n = tick ? (wrap ? '0 : grav + GW'(1)) : grav;
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rep_n[i] = !btn[i] ? '0 : rise[i] ? RW'(DAS_TICKS) :
                    (tick && rep[i] != '0) ? (rep[i] == RW'(1) ? RW'(ARR_TICKS) : rep[i] - RW'(1)) : rep[i];
         fire[i] = btn[i] && !rise[i] && tick && rep[i] == RW'(1);
      end
   end
   assign set = {wrap, rise[3], rise[2], (rise[1] | fire[1]) & ~both, (rise[0] | fire[0]) & ~both, rise[4]};
   assign hit = pend | set;
   assign pick = hit[5] ? 6'h20 : hit[4] ? 6'h10 : hit[3] ? 6'h08 : hit[2] ? 6'h04 : hit[1] ? 6'h02 : 6'h01;
   assign mv = (src[5] | src[0]) ? DOWN : src[4] ? ROR : src[3] ? ROL : src[2] ? RIGHT : LEFT;
   assign busy = fsm == ISSUE;
   assign trk.move = fsm == ISSUE ? mv : IDLE;
   assign trk.state = state;
   assign trk.frame = frame;
   assign trk.color = color;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) fsm <= EMPTY;
      else fsm <= fsm_n;
   always_comb begin
      fsm_n = fsm;
      pend_n = pend;
      src_n = src;
      ok_n = 1'b0;
      fail_n = 1'b0;
      land_n = 1'b0;
      if (fsm == READY) begin
         pend_n = hit;
         fsm_n = |hit ? ISSUE : READY;
         src_n = |hit ? pick : src;
      end else if (fsm == ISSUE) begin
         ok_n = trk.complete;
         fail_n = !trk.complete;
         land_n = !trk.complete && (src[5] || src[0]);
         pend_n = land_n ? '0 : hit & ~src;
         fsm_n = land_n ? EMPTY : READY;
      end
      if (load) begin
         fsm_n = READY;
         pend_n = '0;
         ok_n = 1'b0;
         fail_n = 1'b0;
         land_n = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev <= '0;
         pend <= '0;
         src <= '0;
         rep <= '0;
         grav <= '0;
         frame <= '0;
         state <= '0;
         color <= '0;
         move_ok <= 1'b0;
         move_fail <= 1'b0;
         landed <= 1'b0;
      end else begin
         prev <= btn;
         pend <= pend_n;
         src <= src_n;
         move_ok <= ok_n;
         move_fail <= fail_n;
         landed <= land_n;
         if (load) begin
            frame <= frame_d;
            state <= state_d;
            color <= color_d;
            rep <= '0;
            grav <= '0;
         end else begin
            if (fsm == ISSUE && trk.complete) frame <= trk.frame_o;
            if (fsm != EMPTY) begin
               rep <= rep_n;
               grav <= grav_n;
            end
         end
      end
   end
endmodule

// File: tb/tb_move_issuer.sv
// tb_move_issuer: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_move_issuer;
   localparam int G = 4, DAS = 10, ARR = 3;
   localparam logic [2:0] M_IDLE = 3'd0, M_LEFT = 3'd1, M_RIGHT = 3'd2, M_ROL = 3'd3, M_ROR = 3'd4, M_DOWN = 3'd5;
   logic clk = 1'b0, n_rst = 1'b0, tick = 1'b0, load = 1'b0;
   logic btn_left = 1'b0, btn_right = 1'b0, btn_rol = 1'b0, btn_ror = 1'b0, btn_down = 1'b0;
   logic [4:0] state_d = '0;
   logic [4:0][4:0][2:0] frame_d = '0;
   logic [2:0] color_d = '0;
   logic busy, move_ok, move_fail, landed;
   move_issuer_if trk();
   move_issuer #(.GRAVITY_TICKS(G), .DAS_TICKS(DAS), .ARR_TICKS(ARR)) dut (
      .clk(clk), .n_rst(n_rst), .tick(tick),
      .btn_left(btn_left), .btn_right(btn_right), .btn_rol(btn_rol), .btn_ror(btn_ror), .btn_down(btn_down),
      .load(load), .state_d(state_d), .frame_d(frame_d), .color_d(color_d),
      .trk(trk), .busy(busy), .move_ok(move_ok), .move_fail(move_fail), .landed(landed));
   always #5 clk = ~clk;
   int vectors = 0, miscompares = 0;
   int cnt [8];
   // model: mode 0 empty, 1 ready, 2 issue; requests indexed grav, ror, rol, right, left, down
   int m_mode, m_win, m_ticks;
   bit m_pend [6];
   bit m_armed [2];
   int m_held [2];
   bit [4:0] m_prev;
   logic [74:0] m_frame, fr;
   logic [4:0] m_state;
   logic [2:0] m_color;
   bit m_ok, m_fail, m_land;

   function automatic logic [74:0] rand_frame();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[74:0];
   endfunction

   function automatic logic [2:0] exp_move();
      if (m_mode != 2) return M_IDLE;
      case (m_win)
         0, 5: return M_DOWN;
         1: return M_ROR;
         2: return M_ROL;
         3: return M_RIGHT;
         default: return M_LEFT;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0; m_win = -1; m_ticks = 0; m_prev = '0;
      m_pend = '{default: 1'b0}; m_armed = '{default: 1'b0}; m_held = '{default: 0};
      m_frame = '0; m_state = '0; m_color = '0; m_ok = 0; m_fail = 0; m_land = 0;
   endtask

   task automatic model_step();
      bit [4:0] b, e;
      bit r [6];
      bit f;
      b = {btn_down, btn_ror, btn_rol, btn_right, btn_left};
      e = b & ~m_prev;
      m_prev = b;
      m_ok = 0; m_fail = 0; m_land = 0;
      if (load) begin
         m_frame = frame_d; m_state = state_d; m_color = color_d;
         m_mode = 1; m_ticks = 0;
         m_pend = '{default: 1'b0}; m_armed = '{default: 1'b0};
         return;
      end
      if (m_mode == 0) return;
      r = '{default: 1'b0};
      if (tick) begin
         m_ticks++;
         r[0] = (m_ticks % G) == 0;
      end
      r[1] = e[3]; r[2] = e[2]; r[5] = e[4];
      for (int i = 0; i < 2; i++) begin
         f = 0;
         if (!b[i]) m_armed[i] = 0;
         else if (e[i]) begin m_armed[i] = 1; m_held[i] = 0; f = 1; end
         else if (tick && m_armed[i]) begin
            m_held[i]++;
            f = m_held[i] >= DAS && (m_held[i] - DAS) % ARR == 0;
         end
         if (!(b[0] && b[1])) r[4 - i] = f;
      end
      for (int i = 0; i < 6; i++) m_pend[i] |= r[i];
      if (m_mode == 1) begin
         m_win = -1;
         for (int i = 5; i >= 0; i--) if (m_pend[i]) m_win = i;
         if (m_win >= 0) m_mode = 2;
      end else begin
         m_pend[m_win] = 0;
         m_ok = trk.complete; m_fail = !trk.complete;
         if (trk.complete) m_frame = trk.frame_o;
         if (!trk.complete && (m_win == 0 || m_win == 5)) begin
            m_land = 1; m_mode = 0; m_pend = '{default: 1'b0};
         end else m_mode = 1;
      end
   endtask

   task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("trk_move", 75'(trk.move), 75'(exp_move()));
      check("busy", 75'(busy), 75'(m_mode == 2));
      check("move_ok", 75'(move_ok), 75'(m_ok));
      check("move_fail", 75'(move_fail), 75'(m_fail));
      check("landed", 75'(landed), 75'(m_land));
      check("trk_frame", trk.frame, m_frame);
      check("trk_state", 75'(trk.state), 75'(m_state));
      check("trk_color", 75'(trk.color), 75'(m_color));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (n_rst) model_step();
      @(negedge clk);
      compare_all();
      cnt[trk.move]++;
   endtask

   task automatic tick_group(input int idle);
      tick = 1'b1; cycle(); tick = 1'b0;
      repeat (idle) cycle();
   endtask

   task automatic do_load();
      frame_d = rand_frame(); state_d = 5'($urandom()); color_d = 3'($urandom());
      load = 1'b1; cycle(); load = 1'b0;
   endtask

   initial begin
      model_reset();
      cnt = '{default: 0};
      trk.complete = 1'b0; trk.frame_o = '0;
      {btn_down, btn_ror, btn_rol, btn_right, btn_left} = '1;
      repeat (2) begin @(negedge clk); compare_all(); end
      n_rst = 1'b1;
      repeat (4) cycle();
      check("rst_buttons_idle", 75'(cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5]), 75'(0));
      {btn_down, btn_ror, btn_rol, btn_right, btn_left} = '0;
      cycle();
      do_load();
      repeat (3) cycle();
      btn_right = 1'b1; cycle();
      check("right_issue", 75'(trk.move), 75'(M_RIGHT));
      fr = rand_frame(); trk.frame_o = fr; trk.complete = 1'b1; cycle();
      check("right_ok", 75'(move_ok), 75'(1));
      check("right_frame", trk.frame, fr);
      check("right_one_cycle", 75'(trk.move), 75'(M_IDLE));
      btn_right = 1'b0; cycle();
      do_load();
      cnt = '{default: 0};
      btn_left = 1'b1; cycle();
      repeat (18) tick_group(3);
      check("left_das_arr", 75'(cnt[M_LEFT]), 75'(4));
      btn_left = 1'b0;
      repeat (12) tick_group(3);
      check("left_release", 75'(cnt[M_LEFT]), 75'(4));
      do_load();
      cnt = '{default: 0};
      repeat (12) tick_group(2);
      check("gravity_downs", 75'(cnt[M_DOWN]), 75'(3));
      trk.complete = 1'b0;
      repeat (3) tick_group(2);
      tick = 1'b1; cycle(); tick = 1'b0;
      check("grav_refused_down", 75'(trk.move), 75'(M_DOWN));
      cycle();
      check("landed_pulse", 75'(landed), 75'(1));
      check("landed_fail", 75'(move_fail), 75'(1));
      cnt = '{default: 0};
      repeat (8) tick_group(2);
      check("empty_quiet", 75'(cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5]), 75'(0));
      trk.complete = 1'b1;
      do_load();
      repeat (3) tick_group(2);
      tick = 1'b1; btn_ror = 1'b1; cycle(); tick = 1'b0;
      check("grav_first", 75'(trk.move), 75'(M_DOWN));
      cycle();
      check("gap_ready", 75'(trk.move), 75'(M_IDLE));
      cycle();
      check("ror_second", 75'(trk.move), 75'(M_ROR));
      btn_ror = 1'b0; cycle();
      do_load();
      repeat (3) tick_group(2);
      tick = 1'b1; btn_ror = 1'b1; cycle(); tick = 1'b0;
      cycle();
      do_load();
      cnt = '{default: 0};
      repeat (6) cycle();
      check("load_clears_ror", 75'(cnt[M_ROR]), 75'(0));
      btn_ror = 1'b0; cycle();
      btn_rol = 1'b1; cycle();
      check("rol_issue", 75'(trk.move), 75'(M_ROL));
      n_rst = 1'b0; #1;
      check("rst_mid_issue_move", 75'(trk.move), 75'(M_IDLE));
      check("rst_mid_issue_busy", 75'(busy), 75'(0));
      model_reset();
      cycle();
      n_rst = 1'b1;
      repeat (3) cycle();
      btn_rol = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 39) == 0) btn_left = ~btn_left;
         if ($urandom_range(0, 39) == 0) btn_right = ~btn_right;
         if ($urandom_range(0, 9) == 0) btn_rol = ~btn_rol;
         if ($urandom_range(0, 9) == 0) btn_ror = ~btn_ror;
         if ($urandom_range(0, 9) == 0) btn_down = ~btn_down;
         tick = $urandom_range(0, 2) == 0;
         load = m_mode == 0 ? $urandom_range(0, 9) == 0 : $urandom_range(0, 149) == 0;
         frame_d = rand_frame(); state_d = 5'($urandom()); color_d = 3'($urandom());
         trk.complete = $urandom_range(0, 4) != 0;
         trk.frame_o = rand_frame();
         cycle();
      end
      load = 1'b0; tick = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/move_issuer.md
# move_issuer

Initiator side of the piece-movement interface: turns player buttons and a gravity timer into single-cycle move requests for the combinational frame tracker, then captures the tracker's result. Holds the working 5x5 piece frame, its shape state and its color. Reports landing when a DOWN move is refused. Sits between the input synchronizers and the tracker, and is reloaded by the spawn logic for each new piece.

## Interface
- GRAVITY_TICKS, 50: ticks per automatic DOWN.
- DAS_TICKS, 10: ticks a left/right button must be held before auto-repeat starts.
- ARR_TICKS, 3: ticks between auto-repeat moves.
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle timebase pulse (frame rate).
- btn_left, btn_right, btn_rol, btn_ror, btn_down  in  1 each  synchronized button levels.
- load  in  1  one-cycle pulse: accept a new piece.
- state_d  in  5  shape state for the new piece.
- frame_d  in  [4:0][4:0][2:0]  frame for the new piece.
- color_d  in  3  color for the new piece.
- trk_move  out  move_t  request to the tracker; IDLE when no request is active.
- trk_state  out  5  held state, driven to the tracker.
- trk_frame  out  [4:0][4:0][2:0]  held frame, driven to the tracker.
- trk_color  out  3  held color.
- trk_complete  in  1  tracker accepted the move.
- trk_frame_o  in  [4:0][4:0][2:0]  tracker result frame.
- busy  out  1  high in ISSUE.
- move_ok, move_fail  out  1  one-cycle result pulses.
- landed  out  1  one-cycle pulse when a DOWN is refused.

## Operation
- FSM states:
  - EMPTY: reset state, no piece.
  - READY: piece held, waiting for a request.
  - ISSUE: one request on trk_move.
- load, in any state: frame, state and color registers take the _d values; all pending flags clear; gravity and repeat counters go to 0; next state READY. load overrides every other event in that cycle.
- Edge detect: a rising edge on a button sets its pending flag. Edges are only registered in READY and ISSUE. Levels are sampled every cycle.
- Auto-repeat (left and right independently):
  - A rising edge loads the repeat counter with DAS_TICKS.
  - While the button is held, each tick decrements the counter.
  - On reaching 0 the block sets the pending flag and reloads ARR_TICKS.
  - Releasing the button clears the counter.
  - Left and right held together: both pending flags are suppressed.
- Gravity: the counter increments on tick in READY/ISSUE. At GRAVITY_TICKS-1 it wraps to 0 and sets grav_pend.
- Priority in READY: grav_pend > ror > rol > right > left > down.
  - The winner's move is driven for exactly one cycle in ISSUE. Gravity and down both issue DOWN.
  - The winner's pending flag clears on leaving ISSUE. Other flags persist.
- End of ISSUE:
  - trk_complete=1: frame register takes trk_frame_o; move_ok pulses; go to READY.
  - trk_complete=0: frame unchanged; move_fail pulses.
  - A refused DOWN (from gravity or soft drop) also pulses landed and goes to EMPTY, clearing all pending flags.
  - Any other refusal goes to READY.
- Rotation does not change the held state. Spawn/rotation logic issues a new load with the updated state_d after move_ok.

## Timing
- Reset values: trk_move=IDLE; trk_state, trk_frame, trk_color all 0; busy, move_ok, move_fail, landed all 0; FSM=EMPTY; all counters and flags 0.
- Latency: an edge in cycle N sets its flag at edge N+1. ISSUE is in cycle N+1. Result pulses and the frame update are visible in cycle N+2.
- The tracker is combinational, so trk_complete/trk_frame_o are sampled at the clock edge that ends ISSUE.
- Minimum spacing between requests is 2 cycles (ISSUE, then READY).
- tick arriving during ISSUE is still counted. A gravity wrap during ISSUE sets grav_pend for the next READY.
- A button edge arriving in the same cycle its flag is being cleared is lost (the clear wins).
- Reset asserted mid-ISSUE: trk_move is IDLE immediately and the tracker result is discarded.

## Test plan
- Reset with all buttons high → trk_move=IDLE, FSM EMPTY, no pulses; releasing n_rst with buttons held issues nothing.
- load, then btn_right rises at cycle 5, trk_complete=1 → trk_move=RIGHT in cycle 6 only; frame=trk_frame_o and move_ok=1 in cycle 7.
- Hold btn_left with DAS=10, ARR=3 → LEFT issued after the edge, then at tick 10, 13, 16; release stops repeats.
- GRAVITY_TICKS=4, no buttons, trk_complete=1 → DOWN issued every 4 ticks.
- Same, but trk_complete=0 → move_fail and landed pulse together, FSM EMPTY, later ticks issue nothing.
- btn_ror edge coincident with gravity wrap → DOWN issued first, ROR in the following ISSUE; load during a pending ROR clears it.
